// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA keystream generator and decryptor. Walks the S-box in an external
// 1-cycle-latency RAM and writes enc XOR keystream bytes to a result RAM.
module prga_decrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_rdata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wdata,
  output logic              dec_wren,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, CAP_SI, RD_SJ, CAP_SJ, WR_J, WR_I, RD_F, CAP_F, WR_D, DONE
  } state_t;

  localparam logic [MSG_AW:0] LAST_K = (MSG_AW+1)'(MSG_LEN - 1);

  state_t          state;
  logic [7:0]      i, j, si, sj, f;
  logic [MSG_AW:0] k;
  logic [7:0]      j_upd;
  logic [7:0]      f_addr;

  // 8-bit sums wrap silently, which is exactly the mod-256 arithmetic RC4 needs.
  assign j_upd  = j + s_rdata;
  assign f_addr = si + sj;

  // The ROM address tracks k for many cycles before WR_D, so enc_rdata is
  // already stable when the keystream byte is combined with it.
  assign enc_addr  = k[MSG_AW-1:0];
  assign dec_wdata = dec_wren ? (f ^ enc_rdata) : 8'h00;

  // Outputs are set on the edge that enters the state they belong to, so each
  // is a flop that lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      f        <= '0;
      k        <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wren   <= 1'b0;
      dec_addr <= '0;
      dec_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case wins,
      // so strobes fall back to 0 without a separate clearing path.
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i      <= 8'd1;
            j      <= 8'd0;
            k      <= '0;
            busy   <= 1'b1;
            s_addr <= 8'd1;
            state  <= RD_SI;
          end
        end
        RD_SI: state <= CAP_SI;
        CAP_SI: begin
          si     <= s_rdata;
          j      <= j_upd;
          s_addr <= j_upd;
          state  <= RD_SJ;
        end
        RD_SJ: state <= CAP_SJ;
        CAP_SJ: begin
          sj      <= s_rdata;
          s_addr  <= j;
          s_wdata <= si;
          s_wren  <= 1'b1;
          state   <= WR_J;
        end
        WR_J: begin
          // When i == j both writes hit one address with the same value.
          s_addr  <= i;
          s_wdata <= sj;
          s_wren  <= 1'b1;
          state   <= WR_I;
        end
        WR_I: begin
          s_addr <= f_addr;
          state  <= RD_F;
        end
        RD_F: state <= CAP_F;
        CAP_F: begin
          f        <= s_rdata;
          dec_addr <= k[MSG_AW-1:0];
          dec_wren <= 1'b1;
          state    <= WR_D;
        end
        WR_D: begin
          if (k == LAST_K) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k      <= k + 1'b1;
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            state  <= RD_SI;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
